asrm_bus_initiator: RTL
=======================

// Module: asrm_bus_initiator
// PURPOSE
//   Bus master for the peripheral system bus (enable/addr/write_en/data_in/data_out).
//   Turns valid/ready command transactions into single or burst bus reads/writes.
//   Returns results on a valid/ready response channel.
//   Sits between a host-side agent (debug bridge, DMA, test access) and the OR-combined peripheral bus.
// PARAMETERS
//   word_size       16  data width of bus and command/response channels
//   base_addr_size  16  bus address width
//   read_latency    1   cycles enable/addr are held per read beat before data_out is sampled (>=1)
//   len_size        4   width of cmd_len (burst beats minus one)
// PORTS
//   clk        in   1               system clock, all state on rising edge
//   reset      in   1               asynchronous, active-high reset
//   cmd_valid  in   1               command present
//   cmd_ready  out  1               initiator idle, command accepted on valid&&ready edge
//   cmd_write  in   1               1=write, 0=read
//   cmd_addr   in   base_addr_size  first bus address
//   cmd_wdata  in   word_size       write data (repeated on every write beat)
//   cmd_len    in   len_size        beats-1 (0 = single access)
//   rsp_valid  out  1               response present
//   rsp_ready  in   1               response consumed on valid&&ready edge
//   rsp_data   out  word_size       read data; 0 for write acknowledge
//   rsp_last   out  1               final response of the command
//   busy       out  1               state != IDLE
//   enable     out  1               bus select to peripherals
//   addr       out  base_addr_size  bus address
//   write_en   out  1               bus write strobe
//   data_in    out  word_size       data driven to peripherals' data_in
//   data_out   in   word_size       OR-combined read data from peripherals
// BEHAVIOUR
//   States: IDLE, ACCESS, RESP. Reset (async) -> IDLE, every output 0 except cmd_ready=1.
//   IDLE: cmd_ready=1, bus outputs 0. On cmd_valid&&cmd_ready, latch cmd_*, clear beat count -> ACCESS.
//   ACCESS write beat: exactly 1 cycle with enable=1, write_en=1, addr=cur_addr, data_in=cmd_wdata.
//     Peripheral captures at the closing edge.
//     More beats: cur_addr+1 (wraps modulo 2^base_addr_size), stay in ACCESS, no gap cycle.
//     Final beat -> RESP with rsp_data=0, rsp_last=1. Exactly one response per write command.
//   ACCESS read beat: enable=1, write_en=0, addr=cur_addr held for read_latency cycles.
//     data_out registered into rsp_data at the edge closing the last of those cycles -> RESP.
//     rsp_last=1 iff final beat. One response per read beat.
//   RESP: rsp_valid=1. enable/write_en=0; addr and data_in hold 0.
//     rsp_data/rsp_last stable until rsp_ready.
//     On handshake: next read beat -> ACCESS (cur_addr+1); else -> IDLE.
//   Latency (defaults): command accept edge -> 1 ACCESS cycle -> rsp_valid on next cycle.
//     rsp_ready held high -> read bursts run 2 cycles/beat.
//   cmd_ready=0 whenever busy; cmd_valid while busy is ignored, no state change.
//   write_en is never asserted without enable, and never outside ACCESS.
//   Reset mid-command: immediate return to IDLE, bus outputs drop to 0 asynchronously.
//     Pending response discarded, no further rsp_valid for that command.
//   Burst counter and address increment use len_size / base_addr_size width; no overflow flag.
// CONFIGURATION
//   ASRM_INITIATOR_BURST_EN defined: cmd_len honoured, bursts of 1..2^len_size beats.
//   Undefined: cmd_len port present but ignored (treated as 0).
//     Every command is single-beat, rsp_last is always 1 with rsp_valid, burst counter not synthesised.
// TESTING
//   Write single: cmd addr=16'hFF00, wdata=16'h00A5.
//     -> one cycle enable=1, write_en=1, addr=FF00, data_in=00A5.
//     -> next cycle rsp_valid=1, rsp_data=0, rsp_last=1.
//   Read single: data_out=16'h003C when addr==FF02, else 0; read FF02.
//     -> rsp_data=003C, rsp_last=1, rsp_valid in cycle after ACCESS.
//   Burst read (BURST_EN), addr=FFFE, len=3.
//     -> addrs FFFE, FFFF, 0000, 0001; 4 responses, rsp_last only on 4th.
//     rsp_ready low 5 cycles on 2nd response -> enable=0 and rsp_data stable throughout.
//   read_latency=3: data_out=1, 2, 3 across the 3 enable cycles.
//     -> enable/addr constant 3 cycles, rsp_data=3.
//   Reset pulse during 2nd beat of a 4-beat write.
//     -> enable, write_en, rsp_valid=0 immediately, cmd_ready=1 after release, no further responses.
//   cmd_valid pulsed while busy -> cmd_ready=0, command ignored.
//     Original command completes unchanged; next command accepted only from IDLE.

Source files
------------

// File: rtl/asrm_bus_initiator.sv
// asrm_bus_initiator: peripheral bus master.
// It turns valid/ready commands into single or burst reads and writes on the
// enable/addr/write_en/data_in/data_out peripheral bus. Results come back on a
// valid/ready response channel.
// Optional feature macro: ASRM_INITIATOR_BURST_EN.
//   When defined, cmd_len is honoured and bursts are 1..2^len_size beats.
//   When undefined, every command is single-beat and no burst counter is built.
module asrm_bus_initiator #(
  parameter int word_size      = 16,
  parameter int base_addr_size = 16,
  parameter int read_latency   = 1,
  parameter int len_size       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [base_addr_size-1:0] cmd_addr,
  input  logic [word_size-1:0]      cmd_wdata,
  input  logic [len_size-1:0]       cmd_len,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [word_size-1:0]      rsp_data,
  output logic                      rsp_last,
  output logic                      busy,
  output logic                      enable,
  output logic [base_addr_size-1:0] addr,
  output logic                      write_en,
  output logic [word_size-1:0]      data_in,
  input  logic [word_size-1:0]      data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int LAT_W = (read_latency > 1) ? $clog2(read_latency) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(read_latency - 1);

  state_t                    state;
  state_t                    state_next;
  logic                      cmd_write_q;
  logic [LAT_W-1:0]          lat_cnt;
  logic [base_addr_size-1:0] cur_addr;
  logic [word_size-1:0]      wdata_q;
  logic [word_size-1:0]      rsp_data_q;
  logic                      rsp_last_q;
  logic                      last_beat;
  logic                      beat_done;
  logic                      next_read_beat;

`ifdef ASRM_INITIATOR_BURST_EN
  logic [len_size-1:0] len_q;
  logic [len_size-1:0] beat_cnt;
  assign last_beat = (beat_cnt == len_q);
`else
  logic unused_len;
  assign unused_len = ^cmd_len;
  assign last_beat  = 1'b1;
`endif

  // A write beat always lasts one cycle; a read beat ends on its final latency cycle.
  assign beat_done      = cmd_write_q || (lat_cnt == LAT_LAST);
  assign next_read_beat = !cmd_write_q && !rsp_last_q;

  // Control state: FSM register, latency counter, burst bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_write_q <= 1'b0;
      lat_cnt     <= '0;
`ifdef ASRM_INITIATOR_BURST_EN
      len_q       <= '0;
      beat_cnt    <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_write_q <= cmd_write;
            lat_cnt     <= '0;
`ifdef ASRM_INITIATOR_BURST_EN
            len_q       <= cmd_len;
            beat_cnt    <= '0;
`endif
          end
        end
        ACCESS: begin
          if (beat_done) lat_cnt <= '0;
          else           lat_cnt <= lat_cnt + 1'b1;
`ifdef ASRM_INITIATOR_BURST_EN
          if (cmd_write_q && !last_beat) beat_cnt <= beat_cnt + 1'b1;
`endif
        end
        RESP: begin
`ifdef ASRM_INITIATOR_BURST_EN
          if (rsp_ready && next_read_beat) beat_cnt <= beat_cnt + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath: command fields, running address, captured response word.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr <= cmd_addr;
          wdata_q  <= cmd_wdata;
        end
      end
      ACCESS: begin
        if (cmd_write_q) begin
          if (!last_beat) begin
            cur_addr <= cur_addr + 1'b1;
          end else begin
            rsp_data_q <= '0;
            rsp_last_q <= 1'b1;
          end
        end else if (beat_done) begin
          rsp_data_q <= data_out;
          rsp_last_q <= last_beat;
        end
      end
      RESP: begin
        if (rsp_ready && next_read_beat) cur_addr <= cur_addr + 1'b1;
      end
      default: ;
    endcase
  end

  // Next state and outputs; bus and response outputs decode from state only,
  // so an asynchronous reset drops them immediately.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    enable     = 1'b0;
    write_en   = 1'b0;
    addr       = '0;
    data_in    = '0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_next = ACCESS;
      end
      ACCESS: begin
        enable   = 1'b1;
        write_en = cmd_write_q;
        addr     = cur_addr;
        data_in  = cmd_write_q ? wdata_q : '0;
        if (beat_done && (last_beat || !cmd_write_q)) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_data_q;
        rsp_last  = rsp_last_q;
        if (rsp_ready) state_next = next_read_beat ? ACCESS : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
